i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
- Sits between two register-access requesters and the byte-level I2C master core.
- Requester 0 is the CPU/APB side; requester 1 is a hardware poller.
- Arbitrates round-robin and sequences each register read/write as I2C bus transactions: address, register pointer, 1-4 data bytes.
- Register reads are a pointer write, STOP, then a read transaction; the core has no repeated START.
- Returns read data and an error flag to the winning requester.

Parameters:
- STOP_WAIT, 512, clk cycles held idle after dropping cmd_active, covering STOP generation and core return to HALT. Must be at least 8 SCL quarter-periods at 400k.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  per-requester request valid; fields held stable until accepted
- req_ready  out  2  one-cycle accept pulse; at most one bit set per cycle
- req_write  in  2  per requester: 1=register write, 0=register read
- req_dev  in  14  7-bit device address per requester; req0 in [6:0]
- req_reg  in  16  8-bit register address per requester; req0 in [7:0]
- req_len  in  4  2 bits per requester; byte count minus 1 (0..3 means 1..4 bytes)
- req_wdata  in  64  32 bits per requester; byte0 in [7:0] is sent first
- resp_valid  out  1  one-cycle completion pulse
- resp_id  out  1  requester the response belongs to
- resp_err  out  1  address or data NACK occurred
- resp_rdata  out  32  read bytes, first received in [7:0]; unused bytes 0; 0 on error or write
- cmd_active, cmd_addr[6:0], cmd_read, cmd_high_speed, read_nack, data_valid, data_in[7:0]  out  to core
- addr_err, data_err, data_ready, data_out[7:0]  in  from core

Behaviour:
- Reset values: all outputs 0, state RST_WAIT, wait counter = STOP_WAIT, last_grant=1.
- Reset mid-transaction drops cmd_active immediately. RST_WAIT must expire before a new grant.
- Core contract:
  - cmd_addr, cmd_read and cmd_high_speed change only while cmd_active=0 and after the guard wait.
  - A byte is requested by holding data_valid=1 (with data_in stable on writes) until the one-cycle data_ready pulse.
  - data_valid drops in the cycle after data_ready.
  - read_nack must be stable before data_valid is raised for a byte.
- States:
  - RST_WAIT: count down to 0, then IDLE.
  - IDLE: if any req_valid, grant round-robin. With both valid, grant the requester != last_grant. Pulse req_ready, capture fields into sel_*, update last_grant, go to W_START.
  - W_START: cmd_read=0, cmd_addr=sel_dev, cmd_active=1; data_valid=1 with data_in=sel_reg; go to W_REG.
  - W_REG: on data_ready:
    - addr_err=1 or data_err=1: go to ABORT.
    - write request: load byte0 and go to W_DATA.
    - read request: drop cmd_active, go to GAP (wait STOP_WAIT).
  - W_DATA: per data_ready, check data_err (1 goes to ABORT), decrement remaining. After the last byte, drop cmd_active, go to FIN_WAIT.
  - GAP: at expiry, cmd_read=1, read_nack=(len==0), cmd_active=1, data_valid=1; go to R_DATA.
  - R_DATA: on each data_ready:
    - first byte: if addr_err, go to ABORT.
    - store data_out into byte slot idx.
    - more bytes: set read_nack=(next byte is last) before re-raising data_valid.
    - last byte: drop cmd_active, go to FIN_WAIT.
  - ABORT: data_valid=0, cmd_active=0, err flag set, rdata cleared, go to FIN_WAIT.
  - FIN_WAIT: count STOP_WAIT, then RESP.
  - RESP: resp_valid=1 for one cycle with id/err/rdata, back to IDLE. Rdata and err remain valid until the next resp_valid.
- Latency: accept to resp_valid is bus-bound. Accept occurs the cycle after IDLE sees valid.
- No new grant while a transaction or wait is in progress. req_valid deasserted after accept has no effect.
- Counters sized ceil(log2(STOP_WAIT+1)). len wraps are impossible (2-bit remaining count).

Optional Feature:
- I2C_SEQ_HS_EN defined:
  - Adds input req_hs[1:0].
  - Captured at grant; drives cmd_high_speed for both phases of the transaction.
  - Guard waits remain STOP_WAIT.
- Undefined: no req_hs port; cmd_high_speed tied 0.

Test Plan:
- Req0 write, dev 0x1A, reg 0x05, len=1, wdata 0xBEEF:
  - Core model sees bytes 0x05, 0xEF, 0xBE with cmd_read=0.
  - resp_valid, resp_id=0, err=0, rdata=0.
- Req1 read, dev 0x38, reg 0x10, len=2, model returns 0x11, 0x22, 0x33:
  - Write phase carries 0x10; cmd_active is low for at least STOP_WAIT cycles between phases.
  - read_nack=1 only for the third byte.
  - resp_rdata=0x00332211.
- Both req_valid in the same IDLE cycle after reset: req0 granted first, then req1. Repeated simultaneous requests alternate 0, 1, 0, 1.
- Model asserts addr_err on the read phase: cmd_active drops, resp_err=1, resp_rdata=0, no further data_valid.
- data_err on the second write byte of len=3: remaining bytes not sent, resp_err=1.
- reset asserted during W_DATA: cmd_active=0 the next cycle; a pending req_valid is not accepted until STOP_WAIT cycles after reset release.

Source files
------------

// File: rtl/i2c_reg_sequencer.sv
// Register-access sequencer: round-robin arbitration of two requesters onto a byte-level I2C master.
// Optional macro I2C_SEQ_HS_EN adds req_hs[1:0] to select high-speed mode per request.
module i2c_reg_sequencer #(
  parameter int STOP_WAIT = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_write,
  input  logic [13:0] req_dev,
  input  logic [15:0] req_reg,
  input  logic [3:0]  req_len,
  input  logic [63:0] req_wdata,
`ifdef I2C_SEQ_HS_EN
  input  logic [1:0]  req_hs,
`endif
  output logic        resp_valid,
  output logic        resp_id,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        cmd_active,
  output logic [6:0]  cmd_addr,
  output logic        cmd_read,
  output logic        cmd_high_speed,
  output logic        read_nack,
  output logic        data_valid,
  output logic [7:0]  data_in,
  input  logic        addr_err,
  input  logic        data_err,
  input  logic        data_ready,
  input  logic [7:0]  data_out
);

  localparam int CW = (STOP_WAIT < 1) ? 1 : $clog2(STOP_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(STOP_WAIT);

  // state | meaning: RST_WAIT/GAP/FIN_WAIT guard waits | IDLE arbitrate | W_START/W_REG/W_DATA write phase
  // | R_DATA read phase | ABORT NACK cleanup | RESP response pulse
  typedef enum logic [3:0] {
    RST_WAIT,
    IDLE,
    W_START,
    W_REG,
    W_DATA,
    GAP,
    R_DATA,
    ABORT,
    FIN_WAIT,
    RESP
  } state_t;

  state_t         state;
  logic [CW-1:0]  wait_cnt;
  logic           last_grant;
  logic           gnt;
  logic           sel_id;
  logic           sel_write;
  logic [6:0]     sel_dev;
  logic [7:0]     sel_reg;
  logic [1:0]     sel_len;
  logic [31:0]    sel_wdata;
  logic [1:0]     rem;
  logic [1:0]     idx;
  logic [1:0]     nxt_idx;
  logic [31:0]    rbuf;
  logic           err_flag;

  assign gnt     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  assign nxt_idx = idx + 2'd1;

`ifdef I2C_SEQ_HS_EN
  logic sel_hs;

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_hs <= 1'b0;
    end else if (state == IDLE && req_valid != 2'b00) begin
      sel_hs <= gnt ? req_hs[1] : req_hs[0];
    end
  end

  assign cmd_high_speed = sel_hs;
`else
  assign cmd_high_speed = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_WAIT;
      wait_cnt   <= WAIT_LOAD;
      last_grant <= 1'b1;
      req_ready  <= 2'b00;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      cmd_active <= 1'b0;
      cmd_addr   <= '0;
      cmd_read   <= 1'b0;
      read_nack  <= 1'b0;
      data_valid <= 1'b0;
      data_in    <= '0;
      sel_id     <= 1'b0;
      sel_write  <= 1'b0;
      sel_dev    <= '0;
      sel_reg    <= '0;
      sel_len    <= '0;
      sel_wdata  <= '0;
      rem        <= '0;
      idx        <= '0;
      rbuf       <= '0;
      err_flag   <= 1'b0;
    end else begin
      req_ready  <= 2'b00;
      resp_valid <= 1'b0;
      case (state)
        RST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        IDLE: begin
          if (req_valid != 2'b00) begin
            req_ready  <= gnt ? 2'b10 : 2'b01;
            last_grant <= gnt;
            sel_id     <= gnt;
            sel_write  <= gnt ? req_write[1] : req_write[0];
            sel_dev    <= gnt ? req_dev[13:7] : req_dev[6:0];
            sel_reg    <= gnt ? req_reg[15:8] : req_reg[7:0];
            sel_len    <= gnt ? req_len[3:2] : req_len[1:0];
            sel_wdata  <= gnt ? req_wdata[63:32] : req_wdata[31:0];
            err_flag   <= 1'b0;
            rbuf       <= '0;
            state      <= W_START;
          end
        end

        W_START: begin
          cmd_addr   <= sel_dev;
          cmd_read   <= 1'b0;
          read_nack  <= 1'b0;
          cmd_active <= 1'b1;
          data_in    <= sel_reg;
          data_valid <= 1'b1;
          rem        <= sel_len;
          idx        <= 2'd0;
          state      <= W_REG;
        end

        W_REG: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (addr_err || data_err) begin
              state <= ABORT;
            end else if (sel_write) begin
              data_in <= sel_wdata[7:0];
              state   <= W_DATA;
            end else begin
              // nack is settled here so it is long stable before the read phase raises data_valid
              cmd_active <= 1'b0;
              read_nack  <= (sel_len == 2'd0);
              wait_cnt   <= WAIT_LOAD;
              state      <= GAP;
            end
          end
        end

        W_DATA: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (data_err) begin
              state <= ABORT;
            end else if (rem == 2'd0) begin
              cmd_active <= 1'b0;
              wait_cnt   <= WAIT_LOAD;
              state      <= FIN_WAIT;
            end else begin
              rem     <= rem - 2'd1;
              idx     <= nxt_idx;
              data_in <= sel_wdata[{nxt_idx, 3'b000} +: 8];
            end
          end else if (!data_valid) begin
            data_valid <= 1'b1;
          end
        end

        GAP: begin
          if (wait_cnt == '0) begin
            cmd_read   <= 1'b1;
            read_nack  <= (sel_len == 2'd0);
            cmd_active <= 1'b1;
            data_valid <= 1'b1;
            state      <= R_DATA;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        R_DATA: begin
          if (data_ready) begin
            data_valid <= 1'b0;
            if (idx == 2'd0 && addr_err) begin
              state <= ABORT;
            end else begin
              rbuf[{idx, 3'b000} +: 8] <= data_out;
              if (rem == 2'd0) begin
                cmd_active <= 1'b0;
                wait_cnt   <= WAIT_LOAD;
                state      <= FIN_WAIT;
              end else begin
                rem       <= rem - 2'd1;
                idx       <= nxt_idx;
                read_nack <= (rem == 2'd1);
              end
            end
          end else if (!data_valid) begin
            data_valid <= 1'b1;
          end
        end

        ABORT: begin
          data_valid <= 1'b0;
          cmd_active <= 1'b0;
          err_flag   <= 1'b1;
          rbuf       <= '0;
          wait_cnt   <= WAIT_LOAD;
          state      <= FIN_WAIT;
        end

        FIN_WAIT: begin
          if (wait_cnt == '0) begin
            resp_valid <= 1'b1;
            resp_id    <= sel_id;
            resp_err   <= err_flag;
            resp_rdata <= rbuf;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= RST_WAIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural I2C core model plus response/grant scoreboards.
module tb_i2c_reg_sequencer;
  localparam int SW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [13:0] req_dev;
  logic [15:0] req_reg;
  logic [3:0]  req_len;
  logic [63:0] req_wdata;
`ifdef I2C_SEQ_HS_EN
  logic [1:0]  req_hs = 2'b00;
`endif
  logic        resp_valid;
  logic        resp_id;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        cmd_active;
  logic [6:0]  cmd_addr;
  logic        cmd_read;
  logic        cmd_high_speed;
  logic        read_nack;
  logic        data_valid;
  logic [7:0]  data_in;
  logic        addr_err;
  logic        data_err;
  logic        data_ready;
  logic [7:0]  data_out;

  i2c_reg_sequencer #(.STOP_WAIT(SW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len), .req_wdata(req_wdata),
`ifdef I2C_SEQ_HS_EN
    .req_hs(req_hs),
`endif
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .cmd_active(cmd_active), .cmd_addr(cmd_addr), .cmd_read(cmd_read),
    .cmd_high_speed(cmd_high_speed), .read_nack(read_nack), .data_valid(data_valid),
    .data_in(data_in), .addr_err(addr_err), .data_err(data_err),
    .data_ready(data_ready), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  resp_t      sb[$];
  logic       exp_gnt[$];
  logic [7:0] wr_log[$];
  logic       rn_log[$];
  logic [7:0] rd_data [4];
  logic       inj_rd_addr_err;
  logic       inj_wr_data_err;
  int         gap_seen;
  int         dv_after_err;
  int         act_after_err;
  int         n_total = 0;
  int         n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic wr, input logic [6:0] dev, input logic [7:0] rg,
                         input logic [1:0] len, input logic [31:0] wd);
    req_write[id]          = wr;
    req_dev[id*7 +: 7]     = dev;
    req_reg[id*8 +: 8]     = rg;
    req_len[id*2 +: 2]     = len;
    req_wdata[id*32 +: 32] = wd;
  endtask

  task automatic push_resp(input logic id, input logic err, input logic [31:0] rdata);
    resp_t r;
    r.id = id;
    r.err = err;
    r.rdata = rdata;
    sb.push_back(r);
  endtask

  task automatic issue(input logic [1:0] mask);
    int n;
    n = 0;
    req_valid = mask;
    while (req_valid != 2'b00 && n < 2000) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~req_ready;
      n++;
    end
    check_eq("accept_in_time", 32'(n < 2000), 1);
    req_valid = 2'b00;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("resp_in_time", 32'(n < 2000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Core model: answers each data_valid after a short delay with a one-cycle data_ready.
  initial begin : core_model
    int  dly;
    int  act_cnt;
    int  low_run;
    int  rd_idx;
    logic err_pulsed;
    data_ready = 1'b0;
    addr_err   = 1'b0;
    data_err   = 1'b0;
    data_out   = 8'h00;
    dly = 2; act_cnt = 0; low_run = 0; rd_idx = 0; err_pulsed = 1'b0;
    gap_seen = 0; dv_after_err = 0; act_after_err = 0;
    forever begin
      @(posedge clk); #1;
      if (req_ready != 2'b00) begin
        wr_log.delete();
        rn_log.delete();
        rd_idx = 0;
        err_pulsed = 1'b0;
        gap_seen = 0;
        dv_after_err = 0;
        act_after_err = 0;
      end
      if (cmd_active) begin
        if (low_run > 0 && cmd_read) gap_seen = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (reset) begin
        data_ready = 1'b0;
        addr_err = 1'b0;
        data_err = 1'b0;
        dly = 2;
        act_cnt = 0;
      end else if (data_ready) begin
        data_ready = 1'b0;
        addr_err = 1'b0;
        data_err = 1'b0;
      end else begin
        if (err_pulsed && data_valid) dv_after_err++;
        if (cmd_active && data_valid) begin
          if (dly > 0) begin
            dly--;
          end else begin
            data_ready = 1'b1;
            dly = 2;
            if (!cmd_read) begin
              wr_log.push_back(data_in);
              if (inj_wr_data_err && act_cnt == 2) begin
                data_err = 1'b1;
                err_pulsed = 1'b1;
              end
            end else begin
              rn_log.push_back(read_nack);
              data_out = (rd_idx < 4) ? rd_data[rd_idx] : 8'h00;
              rd_idx++;
              if (inj_rd_addr_err && act_cnt == 0) begin
                addr_err = 1'b1;
                err_pulsed = 1'b1;
              end
            end
            act_cnt++;
          end
        end else begin
          dly = 2;
        end
      end
      if (err_pulsed && cmd_active) act_after_err++;
      if (!cmd_active) act_cnt = 0;
    end
  end

  initial begin : monitor
    logic  g;
    resp_t r;
    forever begin
      @(posedge clk); #1;
      if (req_ready != 2'b00) begin
        if (exp_gnt.size() == 0) begin
          check_eq("grant_unexpected", {30'd0, req_ready}, 0);
        end else begin
          g = exp_gnt.pop_front();
          check_eq("grant", {30'd0, req_ready}, g ? 32'd2 : 32'd1);
        end
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          check_eq("resp_unexpected", {31'd0, resp_valid}, 0);
        end else begin
          r = sb.pop_front();
          check_eq("resp_id", {31'd0, resp_id}, {31'd0, r.id});
          check_eq("resp_err", {31'd0, resp_err}, {31'd0, r.err});
          check_eq("resp_rdata", resp_rdata, r.rdata);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    reset = 1'b1;
    req_valid = 2'b00; req_write = '0; req_dev = '0; req_reg = '0; req_len = '0; req_wdata = '0;
    inj_rd_addr_err = 1'b0;
    inj_wr_data_err = 1'b0;
    for (int i = 0; i < 4; i++) rd_data[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_cmd_active", {31'd0, cmd_active}, 0);
    check_eq("rst_data_valid", {31'd0, data_valid}, 0);
    check_eq("rst_req_ready", {30'd0, req_ready}, 0);
    check_eq("rst_resp", {29'd0, resp_valid, resp_err, resp_id}, 0);
    check_eq("rst_rdata", resp_rdata, 0);
    check_eq("rst_cmd", {cmd_addr, cmd_read, cmd_high_speed, read_nack, data_in}, 0);
    reset = 1'b0;

    // simultaneous requests alternate 0,1,0,1
    for (int p = 0; p < 2; p++) begin
      set_req(0, 1'b1, 7'h11, 8'h01, 2'd0, 32'h000000A0);
      set_req(1, 1'b1, 7'h12, 8'h02, 2'd0, 32'h000000A1);
      exp_gnt.push_back(1'b0);
      exp_gnt.push_back(1'b1);
      push_resp(1'b0, 1'b0, 32'h0);
      push_resp(1'b1, 1'b0, 32'h0);
      issue(2'b11);
      wait_done();
      check_eq("pair_bytes", 32'(wr_log.size()), 2);
      if (wr_log.size() == 2) check_eq("pair_last_byte", {24'd0, wr_log[1]}, 32'hA1);
    end

    // write: reg pointer then two data bytes, low byte first
    set_req(0, 1'b1, 7'h1A, 8'h05, 2'd1, 32'h0000BEEF);
    exp_gnt.push_back(1'b0);
    push_resp(1'b0, 1'b0, 32'h0);
    issue(2'b01);
    wait_done();
    check_eq("wr_count", 32'(wr_log.size()), 3);
    if (wr_log.size() == 3) begin
      check_eq("wr_b0", {24'd0, wr_log[0]}, 32'h05);
      check_eq("wr_b1", {24'd0, wr_log[1]}, 32'hEF);
      check_eq("wr_b2", {24'd0, wr_log[2]}, 32'hBE);
    end
    check_eq("wr_no_reads", 32'(rn_log.size()), 0);
    check_eq("wr_cmd_addr", {25'd0, cmd_addr}, 32'h1A);

    // read of three bytes with a guarded gap between phases
    rd_data[0] = 8'h11; rd_data[1] = 8'h22; rd_data[2] = 8'h33; rd_data[3] = 8'h44;
    set_req(1, 1'b0, 7'h38, 8'h10, 2'd2, 32'h0);
    exp_gnt.push_back(1'b1);
    push_resp(1'b1, 1'b0, 32'h00332211);
    issue(2'b10);
    wait_done();
    check_eq("rd_ptr_count", 32'(wr_log.size()), 1);
    if (wr_log.size() == 1) check_eq("rd_ptr", {24'd0, wr_log[0]}, 32'h10);
    check_eq("rd_nack_log", 32'(rn_log.size() == 3 ? {rn_log[0], rn_log[1], rn_log[2]} : 3'b111), 32'b001);
    check_eq("rd_gap_min", 32'(gap_seen >= SW), 1);
    check_eq("rd_cmd_addr", {25'd0, cmd_addr}, 32'h38);

    // address NACK on the read phase
    inj_rd_addr_err = 1'b1;
    rd_data[0] = 8'h77; rd_data[1] = 8'h88;
    set_req(0, 1'b0, 7'h22, 8'h07, 2'd1, 32'h0);
    exp_gnt.push_back(1'b0);
    push_resp(1'b0, 1'b1, 32'h0);
    issue(2'b01);
    wait_done();
    inj_rd_addr_err = 1'b0;
    check_eq("aerr_read_bytes", 32'(rn_log.size()), 1);
    check_eq("aerr_no_dv", 32'(dv_after_err), 0);
    check_eq("aerr_active_drop", 32'(act_after_err <= 2), 1);

    // data NACK on the second data byte of a four-byte write
    inj_wr_data_err = 1'b1;
    set_req(1, 1'b1, 7'h50, 8'h20, 2'd3, 32'h44332211);
    exp_gnt.push_back(1'b1);
    push_resp(1'b1, 1'b1, 32'h0);
    issue(2'b10);
    wait_done();
    inj_wr_data_err = 1'b0;
    check_eq("derr_bytes", 32'(wr_log.size()), 3);
    if (wr_log.size() == 3) check_eq("derr_last", {24'd0, wr_log[2]}, 32'h22);
    check_eq("derr_no_dv", 32'(dv_after_err), 0);

    // reset in the middle of a write data phase
    set_req(0, 1'b1, 7'h2C, 8'h30, 2'd3, 32'hDDCCBBAA);
    exp_gnt.push_back(1'b0);
    issue(2'b01);
    n = 0;
    while (wr_log.size() < 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("mid_write_reached", 32'(n < 500), 1);
    set_req(1, 1'b0, 7'h33, 8'h44, 2'd0, 32'h0);
    rd_data[0] = 8'h5A;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_drop_active", {31'd0, cmd_active}, 0);
    check_eq("rst_drop_dv", {31'd0, data_valid}, 0);
    exp_gnt.push_back(1'b1);
    push_resp(1'b1, 1'b0, 32'h0000005A);
    req_valid = 2'b10;
    reset = 1'b0;
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("rst_hold_min", 32'(n >= SW), 1);
    check_eq("rst_accept_in_time", 32'(n < 300), 1);
    req_valid = 2'b00;
    wait_done();
    check_eq("post_rst_nack", 32'(rn_log.size() == 1 ? {31'd0, rn_log[0]} : 32'd0), 1);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
